// File: rtl/fdiv_arb_pkg.sv
// Shared types, constants and the round-robin helper for the fdiv arbiter.
package fdiv_arb_pkg;

  localparam int unsigned FLT_W        = 32;
  localparam int unsigned FDIV_LATENCY = 6;
  localparam int unsigned MAX_NREQ     = 16;
  localparam int unsigned ID_W         = $clog2(MAX_NREQ);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // First eligible index after last (mod nreq); returns last when none is eligible.
  function automatic logic [ID_W-1:0] rr_pick(input logic [MAX_NREQ-1:0] eligible,
                                              input logic [ID_W-1:0]     last,
                                              input int unsigned         nreq);
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = int'(nreq); k > 0; k--) begin
      idx = (int'(last) + k) % int'(nreq);
      if (eligible[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/fdiv_rsp_fifo.sv
// First-word-fall-through result FIFO, one per requester.
module fdiv_rsp_fifo
  import fdiv_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [FLT_W-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [FLT_W-1:0]             rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;
  logic             full;

  assign rd_valid = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop      = rd_en && rd_valid;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  // Storage needs no reset; only the head is visible and it is gated by count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (!(wr_en && full)) else $error("fdiv_rsp_fifo: write while full");
  end

endmodule

// File: rtl/fdiv_arbiter.sv
// Round-robin sharing of one fixed-latency fdiv pipe, with per-requester
// result FIFOs reserved ahead of issue through credits.
module fdiv_arbiter
  import fdiv_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned LATENCY    = FDIV_LATENCY,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*FLT_W-1:0] req_x1,
  input  logic [NREQ*FLT_W-1:0] req_x2,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [NREQ*FLT_W-1:0] rsp_y,
  output logic [FLT_W-1:0]      fdiv_x1,
  output logic [FLT_W-1:0]      fdiv_x2,
  input  logic [FLT_W-1:0]      fdiv_y,
  output logic                  busy
);

  localparam int unsigned CRED_W = $clog2(FIFO_DEPTH + 1);

  logic [CRED_W-1:0]   credit     [NREQ];
  logic [CRED_W-1:0]   occ        [NREQ];
  int unsigned         inflight_c [NREQ];
  tag_t                tag        [LATENCY+1];
  logic [ID_W-1:0]     last;
  logic [MAX_NREQ-1:0] eligible_c;
  logic                grant_vld_c;
  logic [ID_W-1:0]     grant_id_c;
  logic [FLT_W-1:0]    sel_x1_c;
  logic [FLT_W-1:0]    sel_x2_c;
  logic [NREQ-1:0]     pop;
  logic [NREQ-1:0]     wr_en;

  // Grant selection from registered credit and current request valids.
  always_comb begin
    eligible_c = '0;
    req_ready  = '0;
    sel_x1_c   = '0;
    sel_x2_c   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      eligible_c[i] = req_valid[i] && (credit[i] != '0);
    end
    grant_vld_c = |eligible_c;
    grant_id_c  = rr_pick(eligible_c, last, NREQ);
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_id_c == ID_W'(i)) begin
        req_ready[i] = grant_vld_c;
        sel_x1_c     = req_x1[i*FLT_W +: FLT_W];
        sel_x2_c     = req_x2[i*FLT_W +: FLT_W];
      end
    end
  end

  assign pop = rsp_valid & rsp_ready;

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      wr_en[i] = tag[LATENCY].vld && (tag[LATENCY].id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fdiv_x1 <= '0;
      fdiv_x2 <= '0;
      last    <= ID_W'(NREQ - 1);
      for (int n = 0; n <= int'(LATENCY); n++) tag[n] <= '0;
      for (int i = 0; i < int'(NREQ); i++) credit[i] <= CRED_W'(FIFO_DEPTH);
    end else begin
      if (grant_vld_c) begin
        fdiv_x1 <= sel_x1_c;
        fdiv_x2 <= sel_x2_c;
        last    <= grant_id_c;
        tag[0]  <= '{vld: 1'b1, id: grant_id_c};
      end else begin
        tag[0]  <= '0;
      end
      for (int n = 1; n <= int'(LATENCY); n++) tag[n] <= tag[n-1];
      // A pop returns its credit only from the following cycle.
      for (int i = 0; i < int'(NREQ); i++) begin
        case ({req_ready[i], pop[i]})
          2'b10:   credit[i] <= credit[i] - CRED_W'(1);
          2'b01:   credit[i] <= credit[i] + CRED_W'(1);
          default: credit[i] <= credit[i];
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < int'(NREQ); gi++) begin : g_fifo
    fdiv_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rstn),
      .wr_en    (wr_en[gi]),
      .wr_data  (fdiv_y),
      .rd_en    (pop[gi]),
      .rd_data  (rsp_y[gi*FLT_W +: FLT_W]),
      .rd_valid (rsp_valid[gi]),
      .count    (occ[gi])
    );
  end

  always_comb begin
    busy = |rsp_valid;
    for (int n = 0; n <= int'(LATENCY); n++) busy = busy | tag[n].vld;
  end

  // Every FIFO slot is either free credit, occupied, or reserved by a tag in flight.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) inflight_c[i] = 0;
    for (int n = 0; n <= int'(LATENCY); n++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (tag[n].vld && (tag[n].id == ID_W'(i))) inflight_c[i] = inflight_c[i] + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        assert (32'(credit[i]) + 32'(occ[i]) + inflight_c[i] == FIFO_DEPTH)
          else $error("fdiv_arbiter: credit invariant broken on requester %0d", i);
      end
    end
  end

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Randomized bench for fdiv_arbiter against a queue-based scoreboard model.
module tb_fdiv_arbiter;
  import fdiv_arb_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned LAT   = 6;
  localparam int unsigned DEPTH = 8;

  logic                  clk;
  logic                  rstn;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*32-1:0]    req_x1;
  logic [NREQ*32-1:0]    req_x2;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*32-1:0]    rsp_y;
  logic [31:0]           fdiv_x1;
  logic [31:0]           fdiv_x2;
  logic [31:0]           fdiv_y;
  logic                  busy;

  fdiv_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .fdiv_x1   (fdiv_x1),
    .fdiv_x2   (fdiv_x2),
    .fdiv_y    (fdiv_y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external divider: fixed latency, distinctive per-operand result.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    return (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]} ^ 32'h5BD1E995;
  endfunction

  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= fmodel(fdiv_x1, fdiv_x2);
    for (int j = 1; j < int'(LAT); j++) pipe[j] <= pipe[j-1];
  end
  assign fdiv_y = pipe[LAT-1];

  typedef struct {
    logic [31:0] y;
    int          rdy;
  } exp_t;

  exp_t        q [NREQ][$];
  int          last_m;
  logic [31:0] mx1, mx2;
  int          cyc;
  int          n_chk, n_pass;
  logic        fix_en;
  logic [31:0] fix_x1, fix_x2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NREQ); i++) q[i].delete();
    last_m = NREQ - 1;
    mx1 = '0;
    mx2 = '0;
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r);
    logic [NREQ-1:0]    exp_rdy, exp_rv;
    logic [NREQ*32-1:0] exp_y;
    logic               exp_busy;
    int                 g, idx;
    @(negedge clk);
    req_valid = v;
    rsp_ready = r;
    for (int i = 0; i < int'(NREQ); i++) begin
      req_x1[i*32 +: 32] = $urandom;
      req_x2[i*32 +: 32] = $urandom;
    end
    if (fix_en) begin
      req_x1[31:0] = fix_x1;
      req_x2[31:0] = fix_x2;
    end
    #1;
    g = -1;
    for (int k = 1; k <= int'(NREQ); k++) begin
      idx = (last_m + k) % int'(NREQ);
      if (g < 0 && v[idx] && q[idx].size() < int'(DEPTH)) g = idx;
    end
    exp_rdy  = '0;
    exp_busy = 1'b0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) begin
      exp_rv[i] = (q[i].size() > 0) && (q[i][0].rdy <= cyc);
      exp_y[i*32 +: 32] = exp_rv[i] ? q[i][0].y : 32'h0;
      if (q[i].size() > 0) exp_busy = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    for (int i = 0; i < int'(NREQ); i++) chk($sformatf("rsp_y%0d", i), rsp_y[i*32 +: 32], exp_y[i*32 +: 32]);
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("fdiv_x1", fdiv_x1, mx1);
    chk("fdiv_x2", fdiv_x2, mx2);
    if (g >= 0) begin
      mx1 = req_x1[g*32 +: 32];
      mx2 = req_x2[g*32 +: 32];
      q[g].push_back('{y: fmodel(mx1, mx2), rdy: cyc + int'(LAT) + 2});
      last_m = g;
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (exp_rv[i] && r[i]) void'(q[i].pop_front());
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    #1;
    chk("rst_fdiv_x1", fdiv_x1, 32'h0);
    chk("rst_fdiv_x2", fdiv_x2, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_y", rsp_y[31:0] | rsp_y[63:32], 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic single_req();
    fix_en = 1'b1;
    fix_x1 = 32'h40400000;
    fix_x2 = 32'h40000000;
    step(2'b01, 2'b11);
    fix_en = 1'b0;
    for (int n = 0; n < 12; n++) step(2'b00, 2'b11);
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    cyc       = 0;
    fix_en    = 1'b0;
    fix_x1    = '0;
    fix_x2    = '0;
    rstn      = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_x1    = '0;
    req_x2    = '0;
    model_clear();
    #2 rstn = 1'b0;
    do_reset();

    single_req();

    for (int n = 0; n < 40; n++) step(2'b11, 2'b11);

    // Stall consumer 0 until its credits run out, then release it.
    for (int n = 0; n < 30; n++) step(2'b11, 2'b10);
    for (int n = 0; n < 30; n++) step(2'b11, 2'b11);

    for (int n = 0; n < 400; n++) step(NREQ'($urandom), NREQ'($urandom));
    for (int n = 0; n < 200; n++) step(NREQ'($urandom), NREQ'($urandom_range(0, 3) == 0 ? 3 : 0));
    for (int n = 0; n < 40; n++) step(2'b00, 2'b11);

    // Reset with divisions in flight: nothing may come out afterwards.
    for (int n = 0; n < 3; n++) step(2'b11, 2'b11);
    do_reset();
    for (int n = 0; n < int'(LAT) + 4; n++) step(2'b00, 2'b11);
    single_req();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
